// File: rtl/rot_field_seq.sv
// ---------------------------------------------------------------------------
// rot_field_seq
//
// Multi-cycle field rotate/shift unit for the ALU datapath. The low FIELD_W
// bits of a DATA_W operand are rotated or shifted one bit per clock under a
// three-state FSM (IDLE -> BUSY -> DONE). Bits above the field pass through
// untouched. Amounts outside 1..FIELD_W-1 and reserved modes complete
// immediately. The result is the operand, and out_range_err flags the
// illegal cases.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous reset, active-low
//   in_valid       operation request
//   in_ready       unit can accept a request (high only in IDLE)
//   in_data        operand A            [DATA_W-1:0]
//   in_amt         unsigned amount B    [AMT_W-1:0]
//   in_mode        0 ROTR, 1 ROTL, 2 SHR, 3 SHL, 4 SAR, 5-7 reserved
//   out_valid      result available (high only in DONE)
//   out_ready      consumer takes the result
//   out_data       result               [DATA_W-1:0]
//   out_range_err  amount >= FIELD_W or reserved mode; result = operand
//   busy           high in BUSY or DONE
// ---------------------------------------------------------------------------
module rot_field_seq #(
  parameter int DATA_W  = 32,
  parameter int FIELD_W = 8,
  parameter int AMT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [2:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_range_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] MODE_ROTR = 3'd0;
  localparam logic [2:0] MODE_ROTL = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_SHL  = 3'd3;
  localparam logic [2:0] MODE_SAR  = 3'd4;

  // A legal BUSY amount is at most FIELD_W-1, so the step counter only
  // needs enough bits to hold that value.
  localparam int              CNT_W   = $clog2(FIELD_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The amount compare is done in a widened domain so that FIELD_W always
  // fits, whatever AMT_W is.
  localparam int                 CMP_W     = AMT_W + 32;
  localparam logic [CMP_W-1:0]   FIELD_LIM = CMP_W'(FIELD_W);

  // One single-bit step on the low field. The upper bits are copied from the
  // input word and never touched, which also covers FIELD_W == DATA_W
  // without a zero-width slice.
  function automatic logic [DATA_W-1:0] field_step(
    input logic [DATA_W-1:0] d,
    input logic [2:0]        m
  );
    logic [FIELD_W-1:0] f;
    logic [DATA_W-1:0]  r;
    f = d[FIELD_W-1:0];
    r = d;
    case (m)
      MODE_ROTR: r[FIELD_W-1:0] = {f[0], f[FIELD_W-1:1]};
      MODE_ROTL: r[FIELD_W-1:0] = {f[FIELD_W-2:0], f[FIELD_W-1]};
      MODE_SHR:  r[FIELD_W-1:0] = {1'b0, f[FIELD_W-1:1]};
      MODE_SHL:  r[FIELD_W-1:0] = {f[FIELD_W-2:0], 1'b0};
      MODE_SAR:  r[FIELD_W-1:0] = {f[FIELD_W-1], f[FIELD_W-1:1]};
      default:   r[FIELD_W-1:0] = f;
    endcase
    return r;
  endfunction

  // Range error: amount not smaller than the field width, or a reserved mode.
  function automatic logic range_check(
    input logic [AMT_W-1:0] amt,
    input logic [2:0]       m
  );
    logic [CMP_W-1:0] wide;
    wide = {32'b0, amt};
    return (wide >= FIELD_LIM) || (m > MODE_SAR);
  endfunction

  state_t              state;
  logic [DATA_W-1:0]   work;
  logic [2:0]          mode_q;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   step_data;
  logic                req_err;
  logic                req_zero;

  assign step_data = field_step(work, mode_q);
  assign req_err   = range_check(in_amt, in_mode);
  assign req_zero  = (in_amt == '0);

  // Single FSM block; every output is a register so nothing downstream sees
  // combinational paths from the request side.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_range_err <= 1'b0;
      busy          <= 1'b0;
      count         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            mode_q   <= in_mode;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (req_err || req_zero) begin
              // Nothing to step: publish the operand unchanged right away.
              state         <= DONE;
              out_valid     <= 1'b1;
              out_data      <= in_data;
              out_range_err <= req_err;
            end else begin
              state <= BUSY;
              count <= in_amt[CNT_W-1:0];
            end
          end
        end

        BUSY: begin
          work  <= step_data;
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            // Last step: the stepped word is the result.
            state         <= DONE;
            out_valid     <= 1'b1;
            out_data      <= step_data;
            out_range_err <= 1'b0;
          end
        end

        DONE: begin
          // out_data keeps the result after handoff until the next DONE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rot_field_seq.sv
// ---------------------------------------------------------------------------
// tb_rot_field_seq
//
// Self-checking bench for rot_field_seq with default parameters
// (DATA_W=32, FIELD_W=8, AMT_W=32). Results, flags and latencies are
// predicted by a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_rot_field_seq;

  localparam int FW = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_amt;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_range_err;
  logic        busy;

  int n_vec;
  int n_err;

  rot_field_seq #(.DATA_W(32), .FIELD_W(FW), .AMT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_amt        (in_amt),
    .in_mode       (in_mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_range_err (out_range_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: whole-amount field operation expressed with integer arithmetic.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] amt,
                                        input logic [2:0] mode, output logic err);
    int f, k, r, sf;
    err = (amt >= 32'(FW)) || (mode > 3'd4);
    if (err || amt == 0) return a;
    f = int'(a[7:0]);
    k = int'(amt);
    case (mode)
      3'd0:    r = (f >> k) | (f << (FW - k));
      3'd1:    r = (f << k) | (f >> (FW - k));
      3'd2:    r = f >> k;
      3'd3:    r = f << k;
      default: begin
        sf = (f >= 128) ? f - 256 : f;
        r  = sf >>> k;
      end
    endcase
    return {a[31:8], r[7:0]};
  endfunction

  // Called at a negedge; presents a request and returns at the negedge
  // following the accepting edge, with the inputs scrambled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] amt, input logic [2:0] mode);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = a;
    in_amt   = amt;
    in_mode  = mode;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = $urandom_range(0, 9);
    in_mode  = 3'($urandom_range(0, 7));
  endtask

  // Waits for the result, checks latency/value/flags, then holds back the
  // consumer for 'hold' cycles checking that everything stays put.
  task automatic wait_result(input logic [31:0] a, input logic [31:0] amt,
                             input logic [2:0] mode, input int hold);
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_lat;
    int          cycles;
    exp_d   = model(a, amt, mode, exp_e);
    exp_lat = (exp_e || amt == 0) ? 1 : 1 + int'(amt);
    cycles  = 1;
    while (!out_valid && cycles < 64) begin
      @(negedge clk);
      cycles++;
    end
    check("latency", 64'(cycles), 64'(exp_lat));
    check("out_data", 64'(out_data), 64'(exp_d));
    check("out_range_err", 64'(out_range_err), 64'(exp_e));
    check("in_ready_done", 64'(in_ready), 64'd0);
    check("busy_done", 64'(busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(out_data), 64'(exp_d));
      check("hold_err", 64'(out_range_err), 64'(exp_e));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
  endtask

  task automatic handoff(input logic [31:0] exp_d);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_handoff_valid", 64'(out_valid), 64'd0);
    check("post_handoff_in_ready", 64'(in_ready), 64'd1);
    check("post_handoff_busy", 64'(busy), 64'd0);
    check("post_handoff_data_kept", 64'(out_data), 64'(exp_d));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] amt,
                        input logic [2:0] mode, input int hold);
    logic [31:0] exp_d;
    logic        exp_e;
    exp_d = model(a, amt, mode, exp_e);
    start_op(a, amt, mode);
    wait_result(a, amt, mode, hold);
    handoff(exp_d);
  endtask

  initial begin
    logic [31:0] a, amt, b, exp_b;
    logic [2:0]  mode;
    logic        e_dummy;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hCAFEF00D;
    in_amt    = 32'd3;
    in_mode   = 3'd0;
    out_ready = 1'b0;

    // Reset held for two edges with a request pending.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(out_range_err), 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(32'h123456A5, 32'd1, 3'd0, 0);
    check("rotr1_value", 64'(out_data), 64'h123456D2);
    run_op(32'h123456A5, 32'd7, 3'd0, 1);
    check("rotr7_value", 64'(out_data), 64'h1234564B);
    run_op(32'h00000081, 32'd3, 3'd1, 0);
    check("rotl3_value", 64'(out_data), 64'h0000000C);
    run_op(32'hFFFFFF80, 32'd2, 3'd4, 0);
    check("sar2_value", 64'(out_data), 64'hFFFFFFE0);
    run_op(32'h000000F0, 32'd4, 3'd2, 0);
    check("shr4_value", 64'(out_data), 64'h0000000F);
    run_op(32'hDEADBEEF, 32'd8, 3'd0, 0);
    check("amt8_err", 64'(out_range_err), 64'd1);
    run_op(32'hDEADBEEF, 32'd2, 3'd6, 0);
    check("mode6_err", 64'(out_range_err), 64'd1);
    run_op(32'hDEADBEEF, 32'hFFFF_FFFF, 3'd1, 0);
    run_op(32'h89ABCDEF, 32'd0, 3'd3, 0);
    check("amt0_value", 64'(out_data), 64'h89ABCDEF);
    run_op(32'h0000_00FF, 32'd7, 3'd3, 0);

    // Backpressure for five cycles with the next request already waiting;
    // it must not be taken on the handoff edge.
    a     = 32'h5555_00C3;
    b     = 32'h0F0F_0F81;
    exp_b = model(b, 32'd2, 3'd0, e_dummy);
    start_op(a, 32'd3, 3'd1);
    wait_result(a, 32'd3, 3'd1, 5);
    in_valid  = 1'b1;
    in_data   = b;
    in_amt    = 32'd2;
    in_mode   = 3'd0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_no_accept_on_handoff", 64'(in_ready), 64'd1);
    check("bp_valid_dropped", 64'(out_valid), 64'd0);
    start_op(b, 32'd2, 3'd0);
    wait_result(b, 32'd2, 3'd0, 0);
    handoff(exp_b);

    // Reset in the middle of a six-step operation.
    start_op(32'h1234_5601, 32'd6, 3'd3);
    repeat (2) begin
      check("midrst_no_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    check("midrst_no_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_stays_idle", 64'(out_valid), 64'd0);
    end
    run_op(32'hA5A5_A5A5, 32'd5, 3'd4, 1);

    // Randomized operations.
    for (int n = 0; n < 200; n++) begin
      a    = $urandom;
      mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) amt = $urandom;
      else amt = $urandom_range(0, 9);
      run_op(a, amt, mode, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
